// File: rtl/conv_win_ctrl.sv
// Convolution window scan controller: walks every output pixel and kernel tap, driving MAC addresses/control.
// Optional stall performance counter enabled by defining CTL_PERF_CNT_EN (adds ctl_stall_cnt port).
//   state   | meaning
//   IDLE    | waiting for ctl_start, counters at 0
//   RUN     | presenting taps, counters advance on accept
//   DONE    | one-cycle scan-complete pulse
module conv_win_ctrl #(
    parameter int IMG_DIM    = 32,
    parameter int KER_DIM    = 5,
    parameter int ADDR_WIDTH = 10,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  ctl_clk,
    input  logic                  ctl_rst_b,
    input  logic                  ctl_start,
    input  logic                  ctl_mac_rdy,
    output logic                  ctl_busy,
    output logic                  ctl_done,
    output logic                  ctl_tap_vld,
    output logic [ADDR_WIDTH-1:0] ctl_in_addr,
    output logic [ADDR_WIDTH-1:0] ctl_wt_addr,
    output logic                  ctl_acc_clr,
    output logic                  ctl_acc_last,
    output logic                  ctl_out_wr,
    output logic [ADDR_WIDTH-1:0] ctl_out_addr
`ifdef CTL_PERF_CNT_EN
    ,
    output logic [15:0]           ctl_stall_cnt
`endif
);

    localparam int OUT_DIM = IMG_DIM - KER_DIM + 1;
    localparam logic [CNT_WIDTH-1:0]  K_MAX = CNT_WIDTH'(KER_DIM - 1);
    localparam logic [CNT_WIDTH-1:0]  O_MAX = CNT_WIDTH'(OUT_DIM - 1);
    localparam logic [CNT_WIDTH-1:0]  C_ONE = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] IMG_A = ADDR_WIDTH'(IMG_DIM);
    localparam logic [ADDR_WIDTH-1:0] KER_A = ADDR_WIDTH'(KER_DIM);
    localparam logic [ADDR_WIDTH-1:0] OUT_A = ADDR_WIDTH'(OUT_DIM);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_WIDTH-1:0]  kc_q, kc_d, kr_q, kr_d, oc_q, oc_d, or_q, or_d;
    logic                  out_wr_q, out_wr_d;
    logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
    logic                  accept, kc_wrap, kr_wrap, oc_wrap, or_wrap;
    logic [ADDR_WIDTH-1:0] row_a, col_a, win_a;

    assign accept  = (state_q == ST_RUN) && ctl_mac_rdy;
    assign kc_wrap = (kc_q == K_MAX);
    assign kr_wrap = (kr_q == K_MAX);
    assign oc_wrap = (oc_q == O_MAX);
    assign or_wrap = (or_q == O_MAX);

    assign row_a = ADDR_WIDTH'(or_q) + ADDR_WIDTH'(kr_q);
    assign col_a = ADDR_WIDTH'(oc_q) + ADDR_WIDTH'(kc_q);
    assign win_a = ADDR_WIDTH'(or_q) * OUT_A + ADDR_WIDTH'(oc_q);

    always_ff @(posedge ctl_clk or negedge ctl_rst_b) begin
        if (!ctl_rst_b) begin
            state_q    <= ST_IDLE;
            kc_q       <= '0;
            kr_q       <= '0;
            oc_q       <= '0;
            or_q       <= '0;
            out_wr_q   <= 1'b0;
            out_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            kc_q       <= kc_d;
            kr_q       <= kr_d;
            oc_q       <= oc_d;
            or_q       <= or_d;
            out_wr_q   <= out_wr_d;
            out_addr_q <= out_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        kc_d       = kc_q;
        kr_d       = kr_q;
        oc_d       = oc_q;
        or_d       = or_q;
        out_wr_d   = 1'b0;
        out_addr_d = out_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (ctl_start) begin
                    state_d = ST_RUN;
                    kc_d    = '0;
                    kr_d    = '0;
                    oc_d    = '0;
                    or_d    = '0;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    kc_d = kc_wrap ? '0 : kc_q + C_ONE;
                    if (kc_wrap) kr_d = kr_wrap ? '0 : kr_q + C_ONE;
                    // Window complete: report it next cycle and step to the next output pixel.
                    if (kc_wrap && kr_wrap) begin
                        out_wr_d   = 1'b1;
                        out_addr_d = win_a;
                        oc_d       = oc_wrap ? '0 : oc_q + C_ONE;
                        if (oc_wrap) begin
                            or_d = or_wrap ? '0 : or_q + C_ONE;
                            if (or_wrap) state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign ctl_busy     = (state_q != ST_IDLE);
    assign ctl_done     = (state_q == ST_DONE);
    assign ctl_tap_vld  = (state_q == ST_RUN);
    assign ctl_in_addr  = row_a * IMG_A + col_a;
    assign ctl_wt_addr  = ADDR_WIDTH'(kr_q) * KER_A + ADDR_WIDTH'(kc_q);
    assign ctl_acc_clr  = ctl_tap_vld && (kc_q == '0) && (kr_q == '0);
    assign ctl_acc_last = ctl_tap_vld && kc_wrap && kr_wrap;
    assign ctl_out_wr   = out_wr_q;
    assign ctl_out_addr = out_addr_q;

`ifdef CTL_PERF_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge ctl_clk or negedge ctl_rst_b) begin
        if (!ctl_rst_b) begin
            stall_q <= '0;
        end else if ((state_q == ST_IDLE) && ctl_start) begin
            stall_q <= '0;
        end else if ((state_q == ST_RUN) && !ctl_mac_rdy && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign ctl_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_conv_win_ctrl.sv
// Self-checking bench for conv_win_ctrl: small 6x6/3x3 instance plus a default-parameter instance.
module tb_conv_win_ctrl;

    localparam int S_IMG = 6;
    localparam int S_KER = 3;
    localparam int S_OUT = S_IMG - S_KER + 1;
    localparam int S_TAPS = S_OUT * S_OUT * S_KER * S_KER;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    logic       s_start = 1'b0, s_rdy = 1'b0;
    logic       s_busy, s_done, s_tap_vld, s_acc_clr, s_acc_last, s_out_wr;
    logic [9:0] s_in_addr, s_wt_addr, s_out_addr;
    logic       d_start = 1'b0, d_rdy = 1'b1;
    logic       d_busy, d_done, d_tap_vld, d_acc_clr, d_acc_last, d_out_wr;
    logic [9:0] d_in_addr, d_wt_addr, d_out_addr;
`ifdef CTL_PERF_CNT_EN
    logic [15:0] s_stall, d_stall;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    conv_win_ctrl #(.IMG_DIM(S_IMG), .KER_DIM(S_KER), .ADDR_WIDTH(10), .CNT_WIDTH(5)) dut_s (
        .ctl_clk(clk), .ctl_rst_b(rst_b), .ctl_start(s_start), .ctl_mac_rdy(s_rdy),
        .ctl_busy(s_busy), .ctl_done(s_done), .ctl_tap_vld(s_tap_vld),
        .ctl_in_addr(s_in_addr), .ctl_wt_addr(s_wt_addr), .ctl_acc_clr(s_acc_clr),
        .ctl_acc_last(s_acc_last), .ctl_out_wr(s_out_wr), .ctl_out_addr(s_out_addr)
`ifdef CTL_PERF_CNT_EN
        , .ctl_stall_cnt(s_stall)
`endif
    );

    conv_win_ctrl dut_d (
        .ctl_clk(clk), .ctl_rst_b(rst_b), .ctl_start(d_start), .ctl_mac_rdy(d_rdy),
        .ctl_busy(d_busy), .ctl_done(d_done), .ctl_tap_vld(d_tap_vld),
        .ctl_in_addr(d_in_addr), .ctl_wt_addr(d_wt_addr), .ctl_acc_clr(d_acc_clr),
        .ctl_acc_last(d_acc_last), .ctl_out_wr(d_out_wr), .ctl_out_addr(d_out_addr)
`ifdef CTL_PERF_CNT_EN
        , .ctl_stall_cnt(d_stall)
`endif
    );

    task automatic test_reset();
        rst_b = 1'b0;
        #1;
        n_checks++;
        if ({s_busy, s_done, s_tap_vld, s_acc_clr, s_acc_last, s_out_wr, s_in_addr, s_wt_addr, s_out_addr} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_small: got busy=%b done=%b vld=%b in=%0d wt=%0d oaddr=%0d, expected all 0",
                     s_busy, s_done, s_tap_vld, s_in_addr, s_wt_addr, s_out_addr);
        end
        n_checks++;
        if ({d_busy, d_done, d_tap_vld, d_acc_clr, d_acc_last, d_out_wr, d_in_addr, d_wt_addr, d_out_addr} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_default: got busy=%b done=%b vld=%b in=%0d, expected all 0",
                     d_busy, d_done, d_tap_vld, d_in_addr);
        end
`ifdef CTL_PERF_CNT_EN
        n_checks++;
        if (s_stall !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stall_cnt: got %0d expected 0", s_stall);
        end
`endif
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
    endtask

    // Runs one full scan on the small instance, entered and left on a negedge in IDLE.
    // stall_at/stall_len: deterministic stall; rnd: random rdy; poke: pulse start in RUN and DONE.
    task automatic run_small(input string name, input int stall_at, input int stall_len,
                             input bit rnd, input bit poke);
        int exp_in[$], exp_wt[$];
        bit exp_clr[$], exp_last[$];
        int win6[9] = '{8, 9, 10, 14, 15, 16, 20, 21, 22};
        int t = 0, cyc = 0, stalls = 0, stall_left = stall_len, done_cnt = 0, wr_cnt = 0;
        int pend_addr = 0;
        bit pend = 0, finished = 0, rdy;
        for (int orow = 0; orow < S_OUT; orow++)
            for (int ocol = 0; ocol < S_OUT; ocol++)
                for (int kr = 0; kr < S_KER; kr++)
                    for (int kc = 0; kc < S_KER; kc++) begin
                        exp_in.push_back((orow + kr) * S_IMG + ocol + kc);
                        exp_wt.push_back(kr * S_KER + kc);
                        exp_clr.push_back(kr == 0 && kc == 0);
                        exp_last.push_back(kr == S_KER - 1 && kc == S_KER - 1);
                    end
        s_start = 1'b1;
        s_rdy   = 1'(($urandom & 1));
        @(negedge clk);
        s_start = 1'b0;
        while (cyc < 2000) begin
            cyc++;
            s_start = 1'b0;
            n_checks++;
            if (s_out_wr !== pend || (pend && s_out_addr !== 10'(pend_addr))) begin
                n_fail++;
                $display("FAIL %s out_wr cyc=%0d: got wr=%b addr=%0d expected wr=%b addr=%0d",
                         name, cyc, s_out_wr, s_out_addr, pend, pend_addr);
            end
            if (s_out_wr === 1'b1) wr_cnt++;
            pend = 0;
            if (s_done === 1'b1) done_cnt++;
            if (s_busy !== 1'b1) begin
                finished = 1;
                break;
            end
            if (t < S_TAPS) begin
                n_checks++;
                if ({s_tap_vld, s_done, s_in_addr, s_wt_addr, s_acc_clr, s_acc_last} !==
                    {1'b1, 1'b0, 10'(exp_in[t]), 10'(exp_wt[t]), exp_clr[t], exp_last[t]}) begin
                    n_fail++;
                    $display("FAIL %s tap %0d: got vld=%b done=%b in=%0d wt=%0d clr=%b last=%b expected in=%0d wt=%0d clr=%b last=%b",
                             name, t, s_tap_vld, s_done, s_in_addr, s_wt_addr, s_acc_clr, s_acc_last,
                             exp_in[t], exp_wt[t], exp_clr[t], exp_last[t]);
                end
                if (t / 9 == 6) begin
                    n_checks++;
                    if (s_in_addr !== 10'(win6[t % 9])) begin
                        n_fail++;
                        $display("FAIL %s win6 tap %0d: got in=%0d expected %0d", name, t % 9, s_in_addr, win6[t % 9]);
                    end
                end
                if (rnd) rdy = ($urandom_range(0, 3) != 0);
                else if (t == stall_at && stall_left > 0) begin
                    rdy = 0;
                    stall_left--;
                end else rdy = 1;
                s_rdy = rdy;
                if (poke && t == 70) s_start = 1'b1;
                if (rdy) begin
                    if (exp_last[t]) begin
                        pend = 1;
                        pend_addr = t / (S_KER * S_KER);
                    end
                    t++;
                end else stalls++;
            end else begin
                n_checks++;
                if ({s_done, s_tap_vld} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL %s done_cycle: got done=%b vld=%b expected done=1 vld=0", name, s_done, s_tap_vld);
                end
                s_rdy = 1'(($urandom & 1));
                if (poke) s_start = 1'b1;
            end
            @(negedge clk);
        end
        s_start = 1'b0;
        n_checks++;
        if (!finished || t != S_TAPS || done_cnt != 1 || wr_cnt != S_OUT * S_OUT) begin
            n_fail++;
            $display("FAIL %s totals: got finished=%0d taps=%0d done=%0d out_wr=%0d expected 1/%0d/1/%0d",
                     name, finished, t, done_cnt, wr_cnt, S_TAPS, S_OUT * S_OUT);
        end
        n_checks++;
        if ({s_tap_vld, s_acc_clr, s_acc_last, s_done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s idle_after: got vld=%b clr=%b last=%b done=%b expected 0", name,
                     s_tap_vld, s_acc_clr, s_acc_last, s_done);
        end
`ifdef CTL_PERF_CNT_EN
        n_checks++;
        if (s_stall !== 16'(stalls)) begin
            n_fail++;
            $display("FAIL %s stall_cnt: got %0d expected %0d", name, s_stall, stalls);
        end
`endif
    endtask

    task automatic test_reset_mid();
        s_start = 1'b1;
        s_rdy   = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        repeat (50) @(negedge clk);
        n_checks++;
        if (s_wt_addr !== 10'(50 % 9) || s_tap_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: got vld=%b wt=%0d expected vld=1 wt=%0d", s_tap_vld, s_wt_addr, 50 % 9);
        end
        rst_b = 1'b0;
        #1;
        n_checks++;
        if ({s_busy, s_done, s_tap_vld, s_acc_clr, s_acc_last, s_out_wr, s_in_addr, s_wt_addr, s_out_addr} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b vld=%b in=%0d wt=%0d wr=%b oaddr=%0d expected all 0",
                     s_busy, s_tap_vld, s_in_addr, s_wt_addr, s_out_wr, s_out_addr);
        end
        @(negedge clk);
        rst_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({s_busy, s_done, s_out_wr} !== 3'b000) begin
                n_fail++;
                $display("FAIL reset_mid_after %0d: got busy=%b done=%b wr=%b expected 0", i, s_busy, s_done, s_out_wr);
            end
        end
    endtask

    task automatic test_default_params();
        int wr_cnt = 0;
        int w;
        bit exp_wr;
        d_rdy   = 1'b1;
        d_start = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        for (int orow = 0; orow < 28; orow++)
            for (int ocol = 0; ocol < 28; ocol++)
                for (int kr = 0; kr < 5; kr++)
                    for (int kc = 0; kc < 5; kc++) begin
                        w = orow * 28 + ocol;
                        exp_wr = (kr == 0 && kc == 0 && w > 0);
                        n_checks++;
                        if ({d_tap_vld, d_done, d_in_addr, d_wt_addr, d_acc_clr, d_acc_last} !==
                            {1'b1, 1'b0, 10'((orow + kr) * 32 + ocol + kc), 10'(kr * 5 + kc),
                             1'(kr == 0 && kc == 0), 1'(kr == 4 && kc == 4)}) begin
                            n_fail++;
                            $display("FAIL default_tap w=%0d kr=%0d kc=%0d: got vld=%b in=%0d wt=%0d clr=%b last=%b",
                                     w, kr, kc, d_tap_vld, d_in_addr, d_wt_addr, d_acc_clr, d_acc_last);
                        end
                        n_checks++;
                        if (d_out_wr !== exp_wr || (exp_wr && d_out_addr !== 10'(w - 1))) begin
                            n_fail++;
                            $display("FAIL default_out_wr w=%0d: got wr=%b addr=%0d expected wr=%b addr=%0d",
                                     w, d_out_wr, d_out_addr, exp_wr, w - 1);
                        end
                        if (d_out_wr === 1'b1) wr_cnt++;
                        @(negedge clk);
                    end
        n_checks++;
        if ({d_busy, d_done, d_tap_vld, d_out_wr, d_out_addr} !== {4'b1101, 10'd783}) begin
            n_fail++;
            $display("FAIL default_done: got busy=%b done=%b vld=%b wr=%b addr=%0d expected 1/1/0/1/783",
                     d_busy, d_done, d_tap_vld, d_out_wr, d_out_addr);
        end
        if (d_out_wr === 1'b1) wr_cnt++;
        @(negedge clk);
        n_checks++;
        if ({d_busy, d_done, d_out_wr} !== 3'b000 || wr_cnt != 784) begin
            n_fail++;
            $display("FAIL default_end: got busy=%b done=%b wr=%b out_wr_total=%0d expected 0/0/0/784",
                     d_busy, d_done, d_out_wr, wr_cnt);
        end
    endtask

    initial begin
        test_reset();
        run_small("scan_basic", -1, 0, 1'b0, 1'b0);
        run_small("scan_stall", 40, 3, 1'b0, 1'b0);
        run_small("start_ignored", -1, 0, 1'b0, 1'b1);
        run_small("back_to_back_rnd", -1, 0, 1'b1, 1'b0);
        test_reset_mid();
        run_small("after_reset", -1, 0, 1'b0, 1'b0);
        test_default_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
